// File: rtl/sobel_output_buffer.sv
// Output stage for Sobel results: optional binarisation, end-of-frame tagging,
// and a small first-word-fall-through FIFO drained over valid/ready.
module sobel_output_buffer #(
  parameter int PIXEL_WIDTH    = 8,
  parameter int DEPTH          = 4,
  parameter int FRAME_CNT_BITS = 16
) (
  input  logic                         clk_i,
  input  logic                         nreset_i,
  input  logic                         clear_i,
  input  logic                         px_rdy_i,
  input  logic [PIXEL_WIDTH-1:0]       in_px_i,
  input  logic                         threshold_en_i,
  input  logic [PIXEL_WIDTH-1:0]       threshold_i,
  input  logic [FRAME_CNT_BITS-1:0]    frame_len_i,
  output logic [PIXEL_WIDTH-1:0]       out_px_o,
  output logic                         out_last_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH):0]       level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [PIXEL_WIDTH:0]          mem_q [DEPTH];
  logic [PIXEL_WIDTH:0]          mem_d [DEPTH];
  logic [AW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                 level_q, level_d;
  logic [FRAME_CNT_BITS-1:0]     frame_cnt_q, frame_cnt_d;
  logic                          overflow_q, overflow_d;

  logic [PIXEL_WIDTH-1:0]        stored_px;
  logic                          tag_last;
  logic                          push;
  logic                          pop;
  logic [PIXEL_WIDTH:0]          head;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;

    if (threshold_en_i) begin
      stored_px = (in_px_i >= threshold_i) ? '1 : '0;
    end else begin
      stored_px = in_px_i;
    end

    tag_last = (frame_len_i != '0) &&
               (frame_cnt_q == frame_len_i - FRAME_CNT_BITS'(1));
    pop  = (level_q != '0) && out_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = px_rdy_i && ((level_q != FULL_LVL) || pop);

    if (clear_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      frame_cnt_d = '0;
      overflow_d  = 1'b0;
    end else begin
      // Dropped pixels still advance the counter to keep frame alignment.
      if (px_rdy_i) begin
        frame_cnt_d = tag_last ? '0 : frame_cnt_q + FRAME_CNT_BITS'(1);
        if (!push) begin
          overflow_d = 1'b1;
        end
      end
      if (push) begin
        mem_d[wr_ptr_q] = {tag_last, stored_px};
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign out_valid_o = (level_q != '0);
  assign out_px_o    = out_valid_o ? head[PIXEL_WIDTH-1:0] : '0;
  assign out_last_o  = out_valid_o ? head[PIXEL_WIDTH] : 1'b0;
  assign overflow_o  = overflow_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_sobel_output_buffer.sv
// Bench for sobel_output_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_sobel_output_buffer;

  localparam int PW    = 8;
  localparam int DEPTH = 4;
  localparam int FCB   = 16;

  logic           clk_i = 1'b0;
  logic           nreset_i;
  logic           clear_i;
  logic           px_rdy_i;
  logic [PW-1:0]  in_px_i;
  logic           threshold_en_i;
  logic [PW-1:0]  threshold_i;
  logic [FCB-1:0] frame_len_i;
  logic [PW-1:0]  out_px_o;
  logic           out_last_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic           overflow_o;
  logic [$clog2(DEPTH):0] level_o;

  sobel_output_buffer #(.PIXEL_WIDTH(PW), .DEPTH(DEPTH), .FRAME_CNT_BITS(FCB)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .clear_i(clear_i), .px_rdy_i(px_rdy_i),
    .in_px_i(in_px_i), .threshold_en_i(threshold_en_i), .threshold_i(threshold_i),
    .frame_len_i(frame_len_i), .out_px_o(out_px_o), .out_last_o(out_last_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .overflow_o(overflow_o),
    .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: queue of {last, pixel}, frame position, sticky overflow.
  logic [PW:0] mq[$];
  int          m_cnt;
  bit          m_ovf;
  int          total;
  int          pass_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [PW:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    chk("valid",    32'(out_valid_o), 32'(mq.size() != 0));
    chk("level",    32'(level_o),     32'(mq.size()));
    chk("overflow", 32'(overflow_o),  32'(m_ovf));
    chk("px",       32'(out_px_o),    32'(h[PW-1:0]));
    chk("last",     32'(out_last_o),  32'(h[PW]));
  endtask

  task automatic model_edge();
    int          sz;
    bit          do_pop;
    bit          last;
    logic [PW-1:0] v;
    if (clear_i) begin
      mq.delete();
      m_cnt = 0;
      m_ovf = 0;
      return;
    end
    sz     = mq.size();
    do_pop = (sz != 0) && out_ready_i;
    if (do_pop) void'(mq.pop_front());
    if (px_rdy_i) begin
      v    = threshold_en_i ? ((in_px_i >= threshold_i) ? 8'hFF : 8'h00) : in_px_i;
      last = (frame_len_i != 0) && (m_cnt == int'(frame_len_i) - 1);
      m_cnt = last ? 0 : (m_cnt + 1) % (1 << FCB);
      if (sz < DEPTH || do_pop) mq.push_back({last, v});
      else m_ovf = 1;
    end
  endtask

  // Inputs are held across the edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse(input logic [PW-1:0] v);
    px_rdy_i = 1'b1;
    in_px_i  = v;
    step();
    px_rdy_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin
    total = 0; pass_cnt = 0; m_cnt = 0; m_ovf = 0;
    nreset_i = 1'b0; clear_i = 1'b0; px_rdy_i = 1'b0; in_px_i = '0;
    threshold_en_i = 1'b0; threshold_i = '0; frame_len_i = '0; out_ready_i = 1'b0;
    #12;
    check_all();
    nreset_i = 1'b1;
    step();

    // Passthrough
    out_ready_i = 1'b1;
    pulse(8'h12);
    chk("pass_0", 32'(out_px_o), 32'h12);
    pulse(8'hFF);
    chk("pass_1", 32'(out_px_o), 32'hFF);
    pulse(8'h00);
    chk("pass_lvl", 32'(level_o), 32'd1);
    step();

    // Threshold
    threshold_en_i = 1'b1; threshold_i = 8'h40;
    pulse(8'h3F);
    chk("thr_3f", 32'(out_px_o), 32'h00);
    pulse(8'h40);
    chk("thr_40", 32'(out_px_o), 32'hFF);
    pulse(8'hC8);
    step();
    threshold_en_i = 1'b0;

    // Backpressure and overflow
    do_clear();
    out_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) pulse(8'(i));
    chk("ovf_lvl", 32'(level_o), 32'd4);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    out_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", 32'(out_px_o), 32'(i));
      step();
    end
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    do_clear();
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    // Full with simultaneous pop
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) pulse(8'(i + 16));
    out_ready_i = 1'b1;
    pulse(8'd9);
    chk("fullpop_lvl", 32'(level_o), 32'd4);
    chk("fullpop_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 5; i++) step();

    // Frame tagging
    do_clear();
    frame_len_i = 16'd3;
    for (int i = 1; i <= 7; i++) begin
      pulse(8'(i));
      chk("frame_last", 32'(out_last_o), 32'(i == 3 || i == 6));
    end
    frame_len_i = 16'd0;
    for (int i = 1; i <= 7; i++) begin
      pulse(8'(i));
      chk("frame_nolast", 32'(out_last_o), 32'd0);
    end
    step();

    // Asynchronous reset with entries queued
    out_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) pulse(8'(i + 32));
    #2 nreset_i = 1'b0;
    mq.delete(); m_cnt = 0; m_ovf = 0;
    #1;
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_lvl", 32'(level_o), 32'd0);
    #1 nreset_i = 1'b1;

    // Clear together with a pulse
    for (int i = 1; i <= 3; i++) pulse(8'(i + 48));
    clear_i = 1'b1;
    pulse(8'hAA);
    clear_i = 1'b0;
    chk("clr_lvl", 32'(level_o), 32'd0);
    step();

    // Random traffic
    frame_len_i = 16'd4;
    for (int i = 0; i < 600; i++) begin
      px_rdy_i       = ($urandom_range(0, 99) < 60);
      in_px_i        = 8'($urandom);
      threshold_en_i = $urandom_range(0, 1) == 1;
      threshold_i    = 8'($urandom);
      out_ready_i    = ($urandom_range(0, 99) < 45);
      clear_i        = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 5) frame_len_i = 16'($urandom_range(0, 6));
      step();
    end
    px_rdy_i = 1'b0; clear_i = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
